// File: rtl/dallanma_cozum_sirasi.sv
// dallanma_cozum_sirasi: in-order branch resolution queue that retires predictor updates and issues redirects/squashes.
module dallanma_cozum_sirasi #(
    parameter int DERINLIK = 4,
    parameter int ETK_W = $clog2(DERINLIK)
) (
    input  logic             i_saat,
    input  logic             i_reset,
    input  logic             i_tahmin_gecerli,
    input  logic [31:0]      i_tahmin_buyruk,
    input  logic [31:0]      i_tahmin_adres,
    input  logic             i_tahmin_atlar,
    input  logic [31:0]      i_tahmin_hedef,
    output logic             o_tahmin_hazir,
    output logic [ETK_W-1:0] o_etiket,
    input  logic             i_cozum_gecerli,
    input  logic [ETK_W-1:0] i_cozum_etiket,
    input  logic             i_cozum_atladi,
    input  logic [31:0]      i_cozum_hedef,
    output logic [31:0]      o_eski_buyruk,
    output logic [31:0]      o_eski_buyruk_adresi,
    output logic             o_buyruk_atladi,
    output logic [31:0]      o_atlanan_adres,
    output logic             o_ongoru_yanlis,
    output logic             o_guncelle,
    output logic             o_yonlendir,
    output logic [31:0]      o_yonlendir_adres,
    output logic             o_bos,
    output logic             o_dolu
);
    typedef enum logic [1:0] {BOS, BEKLIYOR, COZULDU} durum_t;
    localparam logic [ETK_W:0] DOLU = (ETK_W+1)'(DERINLIK);

    logic [31:0]      buyruk [DERINLIK];
    logic [31:0]      adres [DERINLIK];
    logic             atlar [DERINLIK];
    logic [31:0]      hedef [DERINLIK];
    durum_t           durum [DERINLIK];
    logic             yanlis [DERINLIK];
    logic             atladi [DERINLIK];
    logic [31:0]      gercek_hedef [DERINLIK];
    logic [ETK_W-1:0] head, tail, off_tag;
    logic [ETK_W:0]   count;
    logic             cozum_ok, cozum_yanlis, squash, alloc, retire;

    assign o_tahmin_hazir = !i_reset && count < DOLU;
    assign o_etiket = tail;
    assign o_bos = count == '0;
    assign o_dolu = count == DOLU;

    always_comb begin
        cozum_ok = i_cozum_gecerli && durum[i_cozum_etiket] == BEKLIYOR;
        cozum_yanlis = (i_cozum_atladi != atlar[i_cozum_etiket]) ||
                       (i_cozum_atladi && i_cozum_hedef != hedef[i_cozum_etiket]);
        squash = cozum_ok && cozum_yanlis;
        alloc = i_tahmin_gecerli && o_tahmin_hazir && !squash;
        retire = durum[head] == COZULDU;
        off_tag = i_cozum_etiket - head;
    end

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            for (int i = 0; i < DERINLIK; i++) begin
                durum[i] <= BOS;
                buyruk[i] <= '0;
                adres[i] <= '0;
                atlar[i] <= 1'b0;
                hedef[i] <= '0;
                yanlis[i] <= 1'b0;
                atladi[i] <= 1'b0;
                gercek_hedef[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            count <= '0;
            o_guncelle <= 1'b0;
            o_eski_buyruk <= '0;
            o_eski_buyruk_adresi <= '0;
            o_buyruk_atladi <= 1'b0;
            o_atlanan_adres <= '0;
            o_ongoru_yanlis <= 1'b0;
            o_yonlendir <= 1'b0;
            o_yonlendir_adres <= '0;
        end else begin
            // an idle update port carries a zero instruction word so the predictor ignores it
            o_guncelle <= retire;
            o_eski_buyruk <= retire ? buyruk[head] : '0;
            o_eski_buyruk_adresi <= retire ? adres[head] : '0;
            o_buyruk_atladi <= retire && atladi[head];
            o_atlanan_adres <= retire ? gercek_hedef[head] : '0;
            o_ongoru_yanlis <= retire && yanlis[head];
            o_yonlendir <= squash;
            o_yonlendir_adres <= !squash ? '0 :
                                 i_cozum_atladi ? i_cozum_hedef : adres[i_cozum_etiket] + 32'd4;
            if (alloc) begin
                buyruk[tail] <= i_tahmin_buyruk;
                adres[tail] <= i_tahmin_adres;
                atlar[tail] <= i_tahmin_atlar;
                hedef[tail] <= i_tahmin_hedef;
                durum[tail] <= BEKLIYOR;
            end
            if (cozum_ok) begin
                durum[i_cozum_etiket] <= COZULDU;
                yanlis[i_cozum_etiket] <= cozum_yanlis;
                atladi[i_cozum_etiket] <= i_cozum_atladi;
                gercek_hedef[i_cozum_etiket] <= i_cozum_hedef;
            end
            // younger than the mispredicted tag means a larger distance from head, still inside the live window
            for (int i = 0; i < DERINLIK; i++)
                if (squash && ETK_W'(ETK_W'(i) - head) > off_tag &&
                    {1'b0, ETK_W'(ETK_W'(i) - head)} < count)
                    durum[i] <= BOS;
            if (retire)
                durum[head] <= BOS;
            head <= head + ETK_W'(retire);
            tail <= squash ? i_cozum_etiket + ETK_W'(1) : tail + ETK_W'(alloc);
            count <= (squash ? {1'b0, off_tag} + (ETK_W+1)'(1) : count + (ETK_W+1)'(alloc))
                     - (ETK_W+1)'(retire);
        end
    end
endmodule

// File: tb/tb_dallanma_cozum_sirasi.sv
// tb_dallanma_cozum_sirasi: directed vectors against hand-computed queue behaviour.
module tb_dallanma_cozum_sirasi;
    logic        i_saat, i_reset;
    logic        i_tahmin_gecerli, i_tahmin_atlar;
    logic [31:0] i_tahmin_buyruk, i_tahmin_adres, i_tahmin_hedef;
    logic        o_tahmin_hazir;
    logic [1:0]  o_etiket;
    logic        i_cozum_gecerli, i_cozum_atladi;
    logic [1:0]  i_cozum_etiket;
    logic [31:0] i_cozum_hedef;
    logic [31:0] o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres, o_yonlendir_adres;
    logic        o_buyruk_atladi, o_ongoru_yanlis, o_guncelle, o_yonlendir, o_bos, o_dolu;
    int          toplam = 0;
    int          hatali = 0;

    dallanma_cozum_sirasi #(.DERINLIK(4)) dut (
        .i_saat(i_saat), .i_reset(i_reset),
        .i_tahmin_gecerli(i_tahmin_gecerli), .i_tahmin_buyruk(i_tahmin_buyruk),
        .i_tahmin_adres(i_tahmin_adres), .i_tahmin_atlar(i_tahmin_atlar),
        .i_tahmin_hedef(i_tahmin_hedef), .o_tahmin_hazir(o_tahmin_hazir), .o_etiket(o_etiket),
        .i_cozum_gecerli(i_cozum_gecerli), .i_cozum_etiket(i_cozum_etiket),
        .i_cozum_atladi(i_cozum_atladi), .i_cozum_hedef(i_cozum_hedef),
        .o_eski_buyruk(o_eski_buyruk), .o_eski_buyruk_adresi(o_eski_buyruk_adresi),
        .o_buyruk_atladi(o_buyruk_atladi), .o_atlanan_adres(o_atlanan_adres),
        .o_ongoru_yanlis(o_ongoru_yanlis), .o_guncelle(o_guncelle),
        .o_yonlendir(o_yonlendir), .o_yonlendir_adres(o_yonlendir_adres),
        .o_bos(o_bos), .o_dolu(o_dolu)
    );

    initial i_saat = 1'b0;
    always #5 i_saat = ~i_saat;

    task automatic kontrol(input string ad, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: got=%h expected=%h", ad, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge i_saat);
        #1;
    endtask

    task automatic ekle(input logic [1:0] t, input logic [31:0] b, input logic [31:0] a,
                        input logic at, input logic [31:0] h);
        kontrol("alloc_tag", o_etiket, t);
        i_tahmin_gecerli = 1'b1;
        i_tahmin_buyruk = b;
        i_tahmin_adres = a;
        i_tahmin_atlar = at;
        i_tahmin_hedef = h;
        tick();
        i_tahmin_gecerli = 1'b0;
    endtask

    task automatic coz(input logic [1:0] t, input logic at, input logic [31:0] h);
        i_cozum_gecerli = 1'b1;
        i_cozum_etiket = t;
        i_cozum_atladi = at;
        i_cozum_hedef = h;
        tick();
        i_cozum_gecerli = 1'b0;
    endtask

    task automatic guncelleme(input string ad, input logic g, input logic [31:0] b,
                              input logic [31:0] a, input logic y);
        kontrol({ad, "_guncelle"}, o_guncelle, g);
        kontrol({ad, "_buyruk"}, o_eski_buyruk, b);
        kontrol({ad, "_adres"}, o_eski_buyruk_adresi, a);
        kontrol({ad, "_yanlis"}, o_ongoru_yanlis, y);
    endtask

    logic [1:0] sira [4];

    initial begin
        i_reset = 1'b1;
        i_tahmin_gecerli = 1'b0; i_tahmin_buyruk = '0; i_tahmin_adres = '0;
        i_tahmin_atlar = 1'b0; i_tahmin_hedef = '0;
        i_cozum_gecerli = 1'b0; i_cozum_etiket = '0; i_cozum_atladi = 1'b0; i_cozum_hedef = '0;
        sira[0] = 2'd2; sira[1] = 2'd0; sira[2] = 2'd1; sira[3] = 2'd3;
        tick();
        tick();
        kontrol("rst_hazir", o_tahmin_hazir, 0);
        kontrol("rst_bos", o_bos, 1);
        kontrol("rst_dolu", o_dolu, 0);
        guncelleme("rst", 0, 0, 0, 0);
        kontrol("rst_yon", o_yonlendir, 0);
        i_reset = 1'b0;
        #1;
        kontrol("post_rst_hazir", o_tahmin_hazir, 1);

        // fill the queue, then a refused fifth request
        for (int k = 0; k < 4; k++)
            ekle(2'(k), 32'h1000 + k, 32'h100 + 32'(16 * k), 1'b0, 32'h0);
        kontrol("full_dolu", o_dolu, 1);
        kontrol("full_hazir", o_tahmin_hazir, 0);
        i_tahmin_gecerli = 1'b1;
        tick();
        i_tahmin_gecerli = 1'b0;
        kontrol("refused_dolu", o_dolu, 1);
        kontrol("refused_tag", o_etiket, 0);

        // out-of-order resolve, in-order retire
        for (int t = 0; t < 6; t++) begin
            i_cozum_gecerli = t < 4;
            i_cozum_etiket = sira[t % 4];
            i_cozum_atladi = 1'b0;
            i_cozum_hedef = '0;
            tick();
            guncelleme("ooo", t >= 2, t >= 2 ? 32'h1000 + t - 2 : 0,
                       t >= 2 ? 32'h100 + 32'(16 * (t - 2)) : 0, 0);
            kontrol("ooo_yon", o_yonlendir, 0);
        end
        i_cozum_gecerli = 1'b0;
        kontrol("ooo_bos", o_bos, 1);

        // taken mispredict squashes the younger entry
        for (int k = 0; k < 3; k++)
            ekle(2'(k), 32'h2000 + k, 32'h100 + 32'(16 * k), 1'b0, 32'h0);
        coz(2'd1, 1'b1, 32'h200);
        kontrol("mis_yon", o_yonlendir, 1);
        kontrol("mis_yon_adres", o_yonlendir_adres, 32'h200);
        kontrol("mis_tail", o_etiket, 2);
        coz(2'd2, 1'b1, 32'h999);
        kontrol("squashed_yon", o_yonlendir, 0);
        coz(2'd0, 1'b0, 32'h0);
        kontrol("mis_wait", o_guncelle, 0);
        tick();
        guncelleme("mis_r0", 1, 32'h2000, 32'h100, 0);
        tick();
        guncelleme("mis_r1", 1, 32'h2001, 32'h110, 1);
        kontrol("mis_r1_atladi", o_buyruk_atladi, 1);
        kontrol("mis_r1_hedef", o_atlanan_adres, 32'h200);
        tick();
        guncelleme("mis_r2", 0, 0, 0, 0);
        kontrol("mis_bos", o_bos, 1);

        // right direction wrong target, then not-taken mispredict
        ekle(2'd2, 32'h3000, 32'h130, 1'b1, 32'h300);
        coz(2'd2, 1'b1, 32'h304);
        kontrol("tgt_yon", o_yonlendir, 1);
        kontrol("tgt_yon_adres", o_yonlendir_adres, 32'h304);
        tick();
        guncelleme("tgt_r", 1, 32'h3000, 32'h130, 1);
        kontrol("tgt_r_hedef", o_atlanan_adres, 32'h304);
        ekle(2'd3, 32'h3001, 32'h140, 1'b1, 32'h400);
        coz(2'd3, 1'b0, 32'h0);
        kontrol("nt_yon", o_yonlendir, 1);
        kontrol("nt_yon_adres", o_yonlendir_adres, 32'h144);
        tick();
        guncelleme("nt_r", 1, 32'h3001, 32'h140, 1);
        kontrol("nt_r_atladi", o_buyruk_atladi, 0);

        // move head to 3 with back-to-back retires
        for (int k = 0; k < 3; k++)
            ekle(2'(k), 32'h4000 + k, 32'h400 + 32'(16 * k), 1'b0, 32'h0);
        for (int k = 0; k < 3; k++)
            coz(2'(k), 1'b0, 32'h0);
        tick();
        guncelleme("b2b", 1, 32'h4002, 32'h420, 0);
        kontrol("b2b_bos", o_bos, 1);

        // wrapped tail, mispredict concurrent with allocate
        ekle(2'd3, 32'h4100, 32'h500, 1'b0, 32'h0);
        ekle(2'd0, 32'h4101, 32'h510, 1'b0, 32'h0);
        i_tahmin_gecerli = 1'b1;
        i_tahmin_adres = 32'h520;
        coz(2'd3, 1'b1, 32'h600);
        i_tahmin_gecerli = 1'b0;
        kontrol("wrap_yon", o_yonlendir, 1);
        kontrol("wrap_yon_adres", o_yonlendir_adres, 32'h600);
        kontrol("wrap_tail", o_etiket, 0);
        kontrol("wrap_bos", o_bos, 0);
        tick();
        guncelleme("wrap_r", 1, 32'h4100, 32'h500, 1);
        kontrol("wrap_r_bos", o_bos, 1);
        kontrol("wrap_r_tail", o_etiket, 0);
        tick();
        kontrol("wrap_idle", o_guncelle, 0);

        // reset with pending work
        for (int k = 0; k < 3; k++)
            ekle(2'(k), 32'h5000 + k, 32'h700 + 32'(16 * k), 1'b0, 32'h0);
        coz(2'd0, 1'b0, 32'h0);
        i_reset = 1'b1;
        coz(2'd1, 1'b1, 32'h700);
        guncelleme("midrst", 0, 0, 0, 0);
        kontrol("midrst_yon", o_yonlendir, 0);
        kontrol("midrst_bos", o_bos, 1);
        kontrol("midrst_hazir", o_tahmin_hazir, 0);
        i_reset = 1'b0;
        #1;
        kontrol("midrst_hazir2", o_tahmin_hazir, 1);
        kontrol("midrst_tail", o_etiket, 0);
        tick();
        kontrol("midrst_idle", o_guncelle, 0);

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end
endmodule

// File: doc/dallanma_cozum_sirasi.md
# dallanma_cozum_sirasi

In-order branch resolution queue and update scheduler for the branch predictor unit. Fetch allocates an entry for every predicted conditional branch; execute resolves entries by tag, possibly out of order. The block retires entries strictly in program order, drives exactly one predictor update per retired branch on the predictor's update port, and issues a one-cycle fetch redirect and a younger-entry squash on a misprediction.

## Interface
- DERINLIK, 4, queue entries; power of two, 2..16; tag width ETK_W = log2(DERINLIK)
- i_saat  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_tahmin_gecerli  in  1  allocate request from fetch (predicted conditional branch)
- i_tahmin_buyruk  in  32  branch instruction word
- i_tahmin_adres  in  32  branch instruction address
- i_tahmin_atlar  in  1  predicted direction
- i_tahmin_hedef  in  32  predicted target
- o_tahmin_hazir  out  1  queue can accept; combinational, = !i_reset && count < DERINLIK
- o_etiket  out  ETK_W  tag of the slot the current request will occupy (= tail index)
- i_cozum_gecerli  in  1  resolution valid from execute
- i_cozum_etiket  in  ETK_W  tag being resolved
- i_cozum_atladi  in  1  actual direction
- i_cozum_hedef  in  32  actual target
- o_eski_buyruk  out  32  predictor update: instruction word; 32'd0 when no update
- o_eski_buyruk_adresi  out  32  predictor update: branch address
- o_buyruk_atladi  out  1  predictor update: actual direction
- o_atlanan_adres  out  32  predictor update: actual target
- o_ongoru_yanlis  out  1  predictor update: entry was mispredicted
- o_guncelle  out  1  update strobe, one cycle per retired entry
- o_yonlendir  out  1  fetch redirect strobe
- o_yonlendir_adres  out  32  correct next PC
- o_bos, o_dolu  out  1  count == 0 / count == DERINLIK

## Operation
- Storage: DERINLIK slots {buyruk, adres, atlar, hedef, durum, yanlis, atladi, gercek_hedef}; durum ∈ {BOS, BEKLIYOR, COZULDU}. Head/tail pointers ETK_W bits, wrap modulo DERINLIK; count 0..DERINLIK (ETK_W+1 bits).
- Allocate: accepted when i_tahmin_gecerli && o_tahmin_hazir and no squash this cycle; slot[tail] ← inputs, durum BEKLIYOR; tail+1.
- Resolve: accepted only when slot[i_cozum_etiket].durum == BEKLIYOR; otherwise ignored (empty, squashed, or duplicate). Sets COZULDU, records atladi/gercek_hedef; yanlis = (atladi != atlar) || (atladi && gercek_hedef != hedef).
- Mispredict on accepted resolve (yanlis=1): register o_yonlendir=1, o_yonlendir_adres = atladi ? gercek_hedef : adres+4; squash all slots younger than the tag (tag+1 .. tail-1 → BOS); tail ← tag+1; count recomputed as (tag+1 − head) mod range. Same-cycle allocate dropped (wrong path).
- Retire: if slot[head].durum == COZULDU, register update outputs from that slot, o_guncelle=1, slot → BOS, head+1. Max one retire per cycle. Non-retire cycles: o_guncelle=0, o_eski_buyruk=32'd0 (opcode mismatch keeps predictor idle), other update outputs 0.
- Count: +accepted allocate −retire; squash overrides per formula, then −retire if head also retires.
- Full: allocate refused even if a retire occurs same cycle.
- Resolve of head plus allocate same cycle: both take effect; head retires next cycle.

## Timing
- Reset: all slots BOS, head=tail=count=0; o_guncelle, o_yonlendir, o_ongoru_yanlis, o_buyruk_atladi = 0; all 32-bit outputs 0; o_bos=1, o_dolu=0; o_tahmin_hazir=0 while i_reset high. Reset mid-operation discards all entries, no update or redirect emitted.
- Resolve sampled at edge E → o_yonlendir valid the cycle after E (one cycle only).
- Head resolved at edge E → update outputs registered at E+1, valid the cycle after E+1 (latency 2 edges).
- Back-to-back resolved entries retire on consecutive cycles.
- o_etiket, o_tahmin_hazir, o_bos, o_dolu combinational from registered state.

## Test plan
- Reset, allocate 4 (adres 0x100,0x110,0x120,0x130, atlar=0) → tags 0..3, o_dolu=1, 5th request refused, o_tahmin_hazir=0.
- Resolve tags 2,0,1,3 correct (atladi=0) → o_guncelle pulses in order 0x100,0x110,0x120,0x130 on consecutive cycles after tag 0 resolves; o_yonlendir never asserts; o_bos=1 at end.
- Allocate 3, resolve tag 1 atladi=1 hedef=0x200 (predicted 0) → next cycle o_yonlendir=1, adres 0x200; tag 2 squashed, later resolve of tag 2 ignored; retire emits tags 0,1 only with tag1 o_ongoru_yanlis=1.
- Correct direction, wrong target (atlar=1 hedef 0x300, actual 0x304) → redirect 0x304; not-taken mispredict at 0x140 → redirect 0x144.
- Mispredict resolve concurrent with allocate; tail wrap (head=3, tag 3 mispredicts) → allocate dropped, tail=0, count=1.
- Reset asserted with 3 pending entries → no o_guncelle/o_yonlendir, o_bos=1 next cycle.
